// File: rtl/arch_reg_dump_unit.sv
// Streams the architectural register file out as (index, value) words over a
// valid/ready interface. While a dump is running, freeze holds commit so that
// the values streamed out belong to one consistent architectural state.
module arch_reg_dump_unit #(
  parameter int NUM_REGS  = 32,
  parameter int FIRST_REG = 0,
  parameter int ZERO_X0   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dump_start,
  output logic        busy,
  output logic        done,
  output logic        freeze,
  output logic [4:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_data,
  output logic        out_last
);

  // The window of dumped registers has to fit inside the 32-entry file.
  generate
    if ((NUM_REGS < 1) || (NUM_REGS > 32) || (FIRST_REG < 0) ||
        (FIRST_REG + NUM_REGS > 32)) begin : g_bad_params
      $error("arch_reg_dump_unit: FIRST_REG+NUM_REGS must be <= 32 and NUM_REGS >= 1");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  // The pointer is one bit wider than the address so that a window ending at
  // register 31 can step past it without wrapping back to 0.
  localparam logic [5:0] FIRST_PTR = 6'(FIRST_REG);
  localparam logic [5:0] LAST_PTR  = 6'(FIRST_REG + NUM_REGS - 1);

  state_t      state_reg, state_next;
  logic [5:0]  ptr_reg, ptr_next;
  logic        out_valid_reg, out_valid_next;
  logic [4:0]  out_idx_reg, out_idx_next;
  logic [31:0] out_data_reg, out_data_next;
  logic        out_last_reg, out_last_next;
  logic        done_reg, done_next;
  logic [31:0] load_data;

  // The read port is always addressed by the next register to be loaded.
  assign rf_rd_addr = ptr_reg[4:0];

  // Register 0 may be hardwired to zero regardless of what the file returns.
  assign load_data = ((ZERO_X0 != 0) && (ptr_reg == 6'd0)) ? 32'd0 : rf_rd_data;

  // Next-state and output-register logic; every field holds unless changed.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    out_valid_next = out_valid_reg;
    out_idx_next   = out_idx_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dump_start) begin
          out_data_next  = load_data;
          out_idx_next   = ptr_reg[4:0];
          out_last_next  = (ptr_reg == LAST_PTR);
          ptr_next       = ptr_reg + 6'd1;
          out_valid_next = 1'b1;
          state_next     = SEND;
        end
      end
      SEND: begin
        // A start request here is dropped; the running dump is not disturbed.
        if (out_ready) begin
          if (!out_last_reg) begin
            out_data_next = load_data;
            out_idx_next  = ptr_reg[4:0];
            out_last_next = (ptr_reg == LAST_PTR);
            ptr_next      = ptr_reg + 6'd1;
          end else begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            ptr_next       = FIRST_PTR;
            done_next      = 1'b1;
            state_next     = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any dump in progress.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= FIRST_PTR;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= 5'd0;
      out_data_reg  <= 32'd0;
      out_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      out_valid_reg <= out_valid_next;
      out_idx_reg   <= out_idx_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
      done_reg      <= done_next;
    end
  end

  assign busy      = (state_reg == SEND);
  assign freeze    = busy;
  assign done      = done_reg;
  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_arch_reg_dump_unit.sv
// Scoreboard bench: stimulus pushes expected words, a monitor pops on each
// handshake. Four instances cover the parameter corners; one runs at a time.
module tb_arch_reg_dump_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        out_ready;
  logic [3:0]  dump_start;
  logic [3:0]  busy, done, freeze, out_valid, out_last;
  logic [4:0]  rf_rd_addr [4];
  logic [31:0] rf_rd_data [4];
  logic [4:0]  out_idx    [4];
  logic [31:0] out_data   [4];
  logic [31:0] rf [32];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          dut;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  logic       toggle_mode = 1'b0;
  logic [3:0] ready_pat   = 4'b1001;  // ready sequence 1,0,0,1 (bit 0 first)

  always #5 clock = ~clock;

  // Instance 0: full file. 1: window 2..14. 2: single reg 31. 3: x0 not forced.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int P_FIRST = (gi == 1) ? 2 : ((gi == 2) ? 31 : 0);
      localparam int P_NUM   = (gi == 0) ? 32 : ((gi == 1) ? 13 : 1);
      localparam int P_ZERO  = (gi == 3) ? 0 : 1;
      assign rf_rd_data[gi] = rf[rf_rd_addr[gi]];
      arch_reg_dump_unit #(
        .NUM_REGS(P_NUM), .FIRST_REG(P_FIRST), .ZERO_X0(P_ZERO)
      ) u_dut (
        .clock(clock), .reset(reset), .dump_start(dump_start[gi]),
        .busy(busy[gi]), .done(done[gi]), .freeze(freeze[gi]),
        .rf_rd_addr(rf_rd_addr[gi]), .rf_rd_data(rf_rd_data[gi]),
        .out_valid(out_valid[gi]), .out_ready(out_ready),
        .out_idx(out_idx[gi]), .out_data(out_data[gi]), .out_last(out_last[gi])
      );
    end
  endgenerate

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input int k, input int idx, input logic [31:0] d, input logic last);
    exp_t e;
    e.dut = k; e.idx = 5'(idx); e.data = d; e.last = last;
    exp_q.push_back(e);
  endtask

  function automatic int first_of(input int k);
    return (k == 1) ? 2 : ((k == 2) ? 31 : 0);
  endfunction

  // Ready driver: constant high, or the repeating 1,0,0,1 pattern.
  initial begin
    int phase = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (toggle_mode) begin
        out_ready = ready_pat[phase];
        phase = (phase + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops one expected word per handshake and checks held words.
  initial begin
    logic        hold_pending [4];
    logic [4:0]  held_idx     [4];
    logic [31:0] held_data    [4];
    exp_t e;
    for (int k = 0; k < 4; k++) hold_pending[k] = 1'b0;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
        if (reset === 1'b1 && out_valid[k] === 1'b1) begin
          if (hold_pending[k]) begin
            check("hold_idx", 64'(out_idx[k]), 64'(held_idx[k]));
            check("hold_data", 64'(out_data[k]), 64'(held_data[k]));
          end
          if (out_ready) begin
            hold_pending[k] = 1'b0;
            check("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("word_dut", 64'(k), 64'(e.dut));
              check("word_idx", 64'(out_idx[k]), 64'(e.idx));
              check("word_data", 64'(out_data[k]), 64'(e.data));
              check("word_last", 64'(out_last[k]), 64'(e.last));
            end
          end else begin
            hold_pending[k] = 1'b1;
            held_idx[k]     = out_idx[k];
            held_data[k]    = out_data[k];
          end
        end else begin
          hold_pending[k] = 1'b0;
        end
      end
    end
  end

  // Runs one dump on instance k; exp_busy < 0 skips the duration check.
  task automatic run_dump(input int k, input int exp_busy);
    int   busy_cycles = 0;
    logic seen = 1'b0;
    logic freeze_bad = 1'b0;
    @(posedge clock); #1 dump_start[k] = 1'b1;
    @(posedge clock); #1 dump_start[k] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (freeze[k] !== busy[k]) freeze_bad = 1'b1;
      if (done[k] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy[k] === 1'b1) busy_cycles++;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("busy_after_done", 64'(busy[k]), 64'd0);
    if (exp_busy >= 0) check("busy_cycles", 64'(busy_cycles), 64'(exp_busy));
    check("freeze_eq_busy", 64'(freeze_bad), 64'd0);
    @(negedge clock);
    check("done_one_cycle", 64'(done[k]), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("ptr_rewound", 64'(rf_rd_addr[k]), 64'(first_of(k)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] win [13];
    logic        done_bad;
    win = '{32'd5, 32'd10, 32'd15, 32'd5, 32'd0, 32'd15, 32'd15,
            32'd5, 32'd5, 32'd1, 32'd1, 32'd10, 32'd15};
    reset = 1'b0;
    dump_start = 4'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);

    // Reset state of every instance.
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rst_valid", 64'(out_valid[k]), 64'd0);
      check("rst_busy", 64'(busy[k]), 64'd0);
      check("rst_done", 64'(done[k]), 64'd0);
      check("rst_freeze", 64'(freeze[k]), 64'd0);
      check("rst_last", 64'(out_last[k]), 64'd0);
      check("rst_idx", 64'(out_idx[k]), 64'd0);
      check("rst_data", 64'(out_data[k]), 64'd0);
      check("rst_addr", 64'(rf_rd_addr[k]), 64'(first_of(k)));
    end
    reset = 1'b1;

    // Full dump, ready always high, x0 reads 0xDEADBEEF but is forced to 0.
    rf[0] = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) push(0, i, (i == 0) ? 32'd0 : 32'(i * 3), i == 31);
    run_dump(0, 32);

    // Same x0 contents through the instance that does not force zero.
    push(3, 0, 32'hDEADBEEF, 1'b1);
    run_dump(3, 1);

    // Ready toggling 1,0,0,1 with x2=5, x3=10.
    rf[2] = 32'd5; rf[3] = 32'd10;
    for (int i = 0; i < 32; i++)
      push(0, i, (i == 0) ? 32'd0 : ((i == 2) ? 32'd5 : ((i == 3) ? 32'd10 : 32'(i * 3))), i == 31);
    toggle_mode = 1'b1;
    run_dump(0, -1);
    toggle_mode = 1'b0;

    // Window of 13 registers starting at x2.
    for (int i = 0; i < 13; i++) rf[i + 2] = win[i];
    for (int i = 0; i < 13; i++) push(1, i + 2, win[i], i == 12);
    run_dump(1, 13);

    // Single register at the top of the file.
    rf[31] = 32'hCAFE0031;
    push(2, 31, 32'hCAFE0031, 1'b1);
    run_dump(2, 1);

    // Restart request at word 5 is ignored; reset at word 10 aborts.
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
    for (int i = 0; i < 10; i++) push(0, i, 32'(i * 3), 1'b0);
    @(posedge clock); #1 dump_start[0] = 1'b1;
    @(posedge clock); #1 dump_start[0] = 1'b0;
    repeat (5) @(posedge clock);
    #1 dump_start[0] = 1'b1;
    @(posedge clock); #1 dump_start[0] = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    check("abort_valid", 64'(out_valid[0]), 64'd0);
    check("abort_busy", 64'(busy[0]), 64'd0);
    check("abort_freeze", 64'(freeze[0]), 64'd0);
    done_bad = done[0];
    reset = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      if (done[0] !== 1'b0) done_bad = 1'b1;
    end
    check("abort_no_done", 64'(done_bad), 64'd0);
    check("abort_queue", 64'(exp_q.size()), 64'd0);
    check("abort_addr", 64'(rf_rd_addr[0]), 64'd0);

    // Fresh dump after the abort starts again from register 0.
    for (int i = 0; i < 32; i++) push(0, i, 32'(i * 3), i == 31);
    run_dump(0, 32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
